// File: rtl/slow_hold_if.sv
// slow_hold_if -- bus-side bundle for the slow-access hold logic.
//
// Carries the per-cycle decoder selects, the slow-access settings that
// qualify them, and the resulting requests back to clock control.
//
// Signal qualification: there is no valid/ready pair on this bundle. BACT
// acts as the qualifier; the *CS selects are meaningful only while BACT is
// high, and the consumer samples them only on the first cycle of a bus cycle.
// Settings (Slow*, SlowClockGate, SlowTimeout) are level signals, sampled
// whenever the consumer needs them.
//
// Modports:
//   master : drives bus activity and settings, observes the requests
//   slave  : the slow_hold block itself
interface slow_hold_if #(
  parameter int HIT_W = 8
);
  logic             BACT;
  logic             IACKCS;
  logic             VIACS;
  logic             IWMCS;
  logic             SCCCS;
  logic             SCSICS;
  logic             SndCS;
  logic             SlowIACK;
  logic             SlowVIA;
  logic             SlowIWM;
  logic             SlowSCC;
  logic             SlowSCSI;
  logic             SlowSnd;
  logic             SlowClockGate;
  logic [3:0]       SlowTimeout;
  logic             Slow;
  logic             ClkGateReq;
  logic [HIT_W-1:0] HitCnt;

  modport master (
    output BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS,
    output SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
    output SlowClockGate, SlowTimeout,
    input  Slow, ClkGateReq, HitCnt
  );

  modport slave (
    input  BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS,
    input  SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
    input  SlowClockGate, SlowTimeout,
    output Slow, ClkGateReq, HitCnt
  );
endinterface

// File: rtl/slow_hold.sv
// slow_hold -- holds the Slow request for a bus cycle that targets a
// peripheral marked slow, plus a programmable tail of SlowTimeout units of
// 2^PRE_W clocks each. Optionally requests the fast clock to be gated.
//
// Ports:
//   CLK       in   system clock, rising edge
//   POR       in   synchronous active-high reset
//   bus       slave modport of slow_hold_if (BACT, selects, settings in;
//             Slow, ClkGateReq, HitCnt out)
//   StateDbg  out  current FSM state (0 IDLE, 1 HOLD, 2 TAIL)
//
// Build option:
//   SLOW_HITCNT_EN  when defined, HitCnt counts slow hits (saturating);
//                   when undefined, HitCnt is tied to zero.
module slow_hold #(
  parameter int PRE_W = 4,
  parameter int HIT_W = 8
) (
  input  logic       CLK,
  input  logic       POR,
  slow_hold_if.slave bus,
  output logic [1:0] StateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t           state;
  state_t           nextState;
  logic             bactR;
  logic [3:0]       cnt;
  logic [PRE_W-1:0] pre;
  logic             slowQ;
  logic             gateQ;

  logic start;
  logic hit;
  logic tick;

  assign start = bus.BACT && !bactR;

  assign hit = start && ((bus.IACKCS && bus.SlowIACK) ||
                         (bus.VIACS  && bus.SlowVIA)  ||
                         (bus.IWMCS  && bus.SlowIWM)  ||
                         (bus.SCCCS  && bus.SlowSCC)  ||
                         (bus.SCSICS && bus.SlowSCSI) ||
                         (bus.SndCS  && bus.SlowSnd));

  assign tick = &pre;

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (hit) nextState = HOLD;
      end
      HOLD: begin
        if (!bus.BACT) nextState = (bus.SlowTimeout == 4'd0) ? IDLE : TAIL;
      end
      TAIL: begin
        // A retrigger outranks the final tick of the running tail.
        if (hit)                          nextState = HOLD;
        else if (tick && (cnt == 4'd1))   nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (POR) begin
      state <= IDLE;
      slowQ <= 1'b0;
      gateQ <= 1'b0;
      cnt   <= 4'd0;
      pre   <= '0;
      // The edge detector keeps following BACT through reset so that a bus
      // cycle already in progress when POR releases is not seen as a fresh
      // start of cycle.
      bactR <= bus.BACT;
    end else begin
      bactR <= bus.BACT;
      state <= nextState;
      slowQ <= (nextState != IDLE);
      gateQ <= (nextState != IDLE) && bus.SlowClockGate;
      if ((state == HOLD) && (nextState == TAIL)) begin
        // Timeout is captured only here; later writes leave the tail alone.
        cnt <= bus.SlowTimeout;
        pre <= '0;
      end else if ((state == TAIL) && (nextState == TAIL)) begin
        pre <= pre + 1'b1;
        if (tick) cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef SLOW_HITCNT_EN
  logic [HIT_W-1:0] hitCnt;

  always_ff @(posedge CLK) begin
    if (POR) begin
      hitCnt <= '0;
    end else if (hit && !(&hitCnt)) begin
      hitCnt <= hitCnt + 1'b1;
    end
  end

  assign bus.HitCnt = hitCnt;
`else
  assign bus.HitCnt = '0;
`endif

  assign bus.Slow       = slowQ;
  assign bus.ClkGateReq = gateQ;
  assign StateDbg       = state;

endmodule

// File: tb/tb_slow_hold.sv
module tb_slow_hold;

  localparam logic [5:0] SEL_IACK = 6'b100000;
  localparam logic [5:0] SEL_VIA  = 6'b010000;
  localparam logic [5:0] SEL_IWM  = 6'b001000;
  localparam logic [5:0] SEL_SCC  = 6'b000100;
  localparam logic [5:0] SEL_SCSI = 6'b000010;
  localparam logic [5:0] SEL_SND  = 6'b000001;
  localparam logic [5:0] SEL_NONE = 6'b000000;
  localparam logic [5:0] SEL_ALL  = 6'b111111;

  logic       CLK;
  logic       POR;
  logic [1:0] StateDbg;

  slow_hold_if #(.HIT_W(8)) bus ();

  slow_hold #(.PRE_W(4), .HIT_W(8)) dut (
    .CLK      (CLK),
    .POR      (POR),
    .bus      (bus.slave),
    .StateDbg (StateDbg)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  int          tests;
  int          failed;
  int          expHits;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    tests++;
    if (act !== e) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, e, $time);
    end
  endtask

  function automatic logic [7:0] exp_hit();
`ifdef SLOW_HITCNT_EN
    return (expHits > 255) ? 8'hFF : expHits[7:0];
`else
    return 8'h00;
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic por, input logic bact, input logic [5:0] cs,
                       input logic [5:0] en, input logic gate, input logic [3:0] tmo);
    POR               = por;
    bus.BACT          = bact;
    bus.IACKCS        = cs[5];
    bus.VIACS         = cs[4];
    bus.IWMCS         = cs[3];
    bus.SCCCS         = cs[2];
    bus.SCSICS        = cs[1];
    bus.SndCS         = cs[0];
    bus.SlowIACK      = en[5];
    bus.SlowVIA       = en[4];
    bus.SlowIWM       = en[3];
    bus.SlowSCC       = en[2];
    bus.SlowSCSI      = en[1];
    bus.SlowSnd       = en[0];
    bus.SlowClockGate = gate;
    bus.SlowTimeout   = tmo;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // Counts consecutive samples with Slow high, bounded.
  task automatic count_tail(output int n);
    n = 0;
    while (bus.Slow === 1'b1 && n < 200) begin
      n++;
      cycle();
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic       por;
    logic       bact;
    logic [5:0] cs;
    logic [5:0] en;
    logic       gate;
    logic [3:0] tmo;
    logic       hit;
    logic       expSlow;
    logic       expGate;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int n;
    int gaps;
    tests   = 0;
    failed  = 0;
    expHits = 0;

    //            por   bact  cs        en        gate  tmo   hit   slow  gate
    vecs[0]  = '{1'b1, 1'b1, SEL_VIA,  SEL_VIA,  1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, SEL_VIA,  SEL_VIA,  1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, SEL_VIA,  SEL_VIA,  1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, SEL_VIA,  SEL_VIA,  1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, SEL_NONE, SEL_VIA,  1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, SEL_SCC,  SEL_VIA,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, SEL_SCC,  SEL_VIA,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, SEL_NONE, SEL_VIA,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, SEL_SCC,  SEL_SCC,  1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, SEL_SCC,  SEL_SCC,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, SEL_SCC,  SEL_SCC,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, SEL_NONE, SEL_SCC,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, SEL_NONE, SEL_SCC,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, SEL_IWM,  SEL_SCSI, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, SEL_SCSI, SEL_SCSI, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, SEL_NONE, SEL_SCSI, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, SEL_SND,  SEL_SND,  1'b1, 4'd0, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b1, SEL_NONE, SEL_SND,  1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 1'b1, SEL_NONE, SEL_SND,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, SEL_NONE, SEL_SND,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, SEL_IACK, SEL_ALL,  1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, SEL_NONE, SEL_ALL,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    drive(1'b1, 1'b1, SEL_VIA, SEL_VIA, 1'b1, 4'd3);
    #2;

    // ---- table: reset, non-slow device, zero tail, mid-cycle select changes
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].por, vecs[i].bact, vecs[i].cs, vecs[i].en, vecs[i].gate, vecs[i].tmo);
      cycle();
      if (vecs[i].hit) expHits++;
      check($sformatf("vec%0d_slow", i), {31'd0, bus.Slow}, {31'd0, vecs[i].expSlow});
      check($sformatf("vec%0d_gate", i), {31'd0, bus.ClkGateReq}, {31'd0, vecs[i].expGate});
      check($sformatf("vec%0d_hitcnt", i), {24'd0, bus.HitCnt}, {24'd0, exp_hit()});
    end

    // ---- 48-cycle tail after a 5-cycle slow bus cycle
    drive(1'b0, 1'b1, SEL_VIA, SEL_VIA, 1'b1, 4'd3);
    cycle();
    expHits++;
    check("tailA_hold_state", {30'd0, StateDbg}, 32'd1);
    check("tailA_gate_hold", {31'd0, bus.ClkGateReq}, 32'd1);
    gaps = 0;
    repeat (4) begin
      cycle();
      if (bus.Slow !== 1'b1) gaps++;
    end
    check("tailA_hold_gaps", gaps, 32'd0);
    drive(1'b0, 1'b0, SEL_NONE, SEL_VIA, 1'b1, 4'd3);
    cycle();
    check("tailA_tail_state", {30'd0, StateDbg}, 32'd2);
    count_tail(n);
    check("tailA_len", n, 32'd48);
    check("tailA_end_gate", {31'd0, bus.ClkGateReq}, 32'd0);
    check("tailA_end_state", {30'd0, StateDbg}, 32'd0);

    // ---- retrigger 20 cycles into a 32-cycle tail
    drive(1'b0, 1'b1, SEL_VIA, SEL_VIA, 1'b0, 4'd2);
    cycle();
    expHits++;
    repeat (2) cycle();
    drive(1'b0, 1'b0, SEL_NONE, SEL_VIA, 1'b0, 4'd2);
    cycle();
    gaps = 0;
    repeat (19) begin
      cycle();
      if (bus.Slow !== 1'b1) gaps++;
    end
    check("retrig_in_tail", {30'd0, StateDbg}, 32'd2);
    drive(1'b0, 1'b1, SEL_VIA, SEL_VIA, 1'b0, 4'd2);
    cycle();
    expHits++;
    check("retrig_state", {30'd0, StateDbg}, 32'd1);
    repeat (2) begin
      cycle();
      if (bus.Slow !== 1'b1) gaps++;
    end
    check("retrig_gaps", gaps, 32'd0);
    drive(1'b0, 1'b0, SEL_NONE, SEL_VIA, 1'b0, 4'd2);
    cycle();
    count_tail(n);
    check("retrig_len", n, 32'd32);
    check("retrig_hitcnt", {24'd0, bus.HitCnt}, {24'd0, exp_hit()});

    // ---- gate cleared and timeout rewritten mid-tail
    drive(1'b0, 1'b1, SEL_VIA, SEL_VIA, 1'b1, 4'd2);
    cycle();
    expHits++;
    cycle();
    drive(1'b0, 1'b0, SEL_NONE, SEL_VIA, 1'b1, 4'd2);
    cycle();
    n = 0;
    while (bus.Slow === 1'b1 && n < 200) begin
      n++;
      if (n == 5) begin
        check("gate_before_clear", {31'd0, bus.ClkGateReq}, 32'd1);
        bus.SlowClockGate = 1'b0;
        bus.SlowTimeout   = 4'd7;
      end
      if (n == 6) check("gate_after_clear", {31'd0, bus.ClkGateReq}, 32'd0);
      cycle();
    end
    check("gate_tail_len", n, 32'd32);

    // ---- POR in the middle of a tail
    drive(1'b0, 1'b1, SEL_VIA, SEL_VIA, 1'b1, 4'd3);
    cycle();
    expHits++;
    drive(1'b0, 1'b0, SEL_NONE, SEL_VIA, 1'b1, 4'd3);
    cycle();
    repeat (10) cycle();
    check("por_pre_state", {30'd0, StateDbg}, 32'd2);
    POR = 1'b1;
    cycle();
    expHits = 0;
    check("por_slow", {31'd0, bus.Slow}, 32'd0);
    check("por_gate", {31'd0, bus.ClkGateReq}, 32'd0);
    check("por_state", {30'd0, StateDbg}, 32'd0);
    check("por_hitcnt", {24'd0, bus.HitCnt}, 32'd0);
    POR = 1'b0;
    cycle();
    check("por_after_slow", {31'd0, bus.Slow}, 32'd0);

    // ---- 300 hits: counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, SEL_VIA, SEL_VIA, 1'b0, 4'd0);
      cycle();
      expHits++;
      drive(1'b0, 1'b0, SEL_NONE, SEL_VIA, 1'b0, 4'd0);
      cycle();
      if (i == 253) check("sat_254", {24'd0, bus.HitCnt}, {24'd0, exp_hit()});
    end
    check("sat_final", {24'd0, bus.HitCnt}, {24'd0, exp_hit()});
    check("sat_idle_slow", {31'd0, bus.Slow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
